sdio_clk_en_ctrl: RTL and testbench
===================================

Name: sdio_clk_en_ctrl

Overview:
Generates the per-cycle enable that drives the SD card clock gating cell's en_i input, placed directly upstream of that cell. Divides clk_i into one-cycle-wide SD clock pulses using a programmable divisor. Stops and restarts the card clock cleanly on flow-control requests (FIFO full/empty) and optional auto-idle, and reports a stop acknowledge to the data path.

Parameters:
DIV_W, 8, width of divisor and period counter
IDLE_W, 8, width of idle pulse limit and idle counter

Ports:
clk_i  in  1  host clock; the gating cell is clocked by the same clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  card clock enable from register file; 0 forces OFF
div_i  in  DIV_W  divisor; one SD pulse every div_i+1 clk_i cycles
stop_req_i  in  1  flow-control stop request (level)
stop_ack_o  out  1  high while the clock is stopped by stop_req_i or idle
auto_idle_i  in  1  enables idle auto-stop
idle_limit_i  in  IDLE_W  number of non-busy SD pulses before auto-stop
bus_busy_i  in  1  command/data engine busy; resets the idle count, wakes from idle
clk_en_o  out  1  to the gating cell's en_i; registered
sd_edge_o  out  1  high in the cycle a gated pulse appears at the gate output (clk_en_o delayed 1 cycle)
state_o  out  2  0=OFF, 1=RUN, 2=STOPPING, 3=STOPPED

Behaviour:
- Reset (async, rst_ni=0): state OFF, cnt=0, div_q=0, idle_cnt=0, clk_en_o=0, sd_edge_o=0, stop_ack_o=0. Release is synchronous to the next clk_i edge.
- The gating cell registers en_i, so a pulse appears at its output one cycle after clk_en_o=1. sd_edge_o = clk_en_o registered once more, aligned to that pulse.
- div_q: latched from div_i on OFF->RUN and at every wrap. Mid-period changes take effect at the next wrap only.
- Period counter, RUN and STOPPING states: cnt increments each cycle. When cnt==div_q, cnt wraps to 0 (a "wrap"). clk_en_o is asserted next cycle for exactly one cycle per wrap.
- div_q=0: wrap every cycle, so clk_en_o is held continuously high (full rate).
- FSM transitions:
  - OFF: clk_en_o=0, cnt=0. When enable_i=1, go to RUN with cnt=0. The first clk_en_o comes div_q+1 cycles after entering RUN.
  - RUN:
    - enable_i=0: go to OFF next cycle. No more clk_en_o; a clk_en_o already registered still completes.
    - stop_req_i=1, or auto-idle condition met: go to STOPPING.
  - STOPPING: counter keeps running. The pulse at the next wrap is suppressed (clk_en_o stays 0). State goes to STOPPED on that wrap; cnt=0.
  - STOPPED: clk_en_o=0, stop_ack_o=1, cnt held at 0. Resume to RUN (cnt=0, div_q reloaded) when stop_req_i=0 and (auto_idle_i=0 or bus_busy_i=1 or the stop was not an idle stop). The idle flag is cleared on resume.
- Priority: enable_i=0 overrides all states and goes to OFF next cycle, from any state.
- Idle counting: in RUN, each emitted pulse with bus_busy_i=0 increments idle_cnt, which saturates. bus_busy_i=1 clears it.
  - Auto-idle condition: auto_idle_i=1, idle_cnt==idle_limit_i, and idle_limit_i!=0. idle_limit_i=0 disables auto-stop.
  - idle_cnt is cleared on leaving RUN.
- stop_ack_o is 1 only in STOPPED. It falls in the same cycle the state leaves STOPPED.
- stop_req_i deasserted while in STOPPING: the stop still completes to STOPPED, then resumes on the next cycle. The minimum stop is one cycle.
- stop_req_i and the enable_i fall in the same cycle: OFF wins; stop_ack_o stays 0.
- Reset asserted mid-period: all outputs go low immediately and asynchronously. No partial pulse occurs because the gate samples en only on posedge.

Test Plan:
- Reset, then enable_i=1 with div_i=3 -> first clk_en_o 4 cycles after RUN entry, then every 4 cycles. sd_edge_o follows 1 cycle later. state_o=1.
- div_i=0 -> clk_en_o continuously 1. Change div_i to 2 mid-run -> period becomes 3 cycles starting exactly at the next wrap, with no short period.
- div_i=3, stop_req_i raised 1 cycle after a pulse -> state 2, next wrap pulse suppressed, state 3, stop_ack_o=1. Drop stop_req_i -> stop_ack_o=0 same cycle as RUN entry, next pulse 4 cycles later.
- auto_idle_i=1, idle_limit_i=5, bus_busy_i=0 -> exactly 5 pulses then STOPPED. Assert bus_busy_i -> resumes. With idle_limit_i=0 -> never auto-stops.
- enable_i dropped during STOPPING and during STOPPED -> OFF next cycle, clk_en_o=0, stop_ack_o=0.
- rst_ni pulsed low mid-period with clk_en_o=1 -> clk_en_o, sd_edge_o, and stop_ack_o go to 0 asynchronously, state_o=0.

Source files
------------

// File: rtl/sdio_clk_en_ctrl.sv
// SD card clock enable generator: divides clk_i into one-cycle enable pulses for the
// downstream clock gate, with clean stop/restart for flow control and auto-idle.
module sdio_clk_en_ctrl #(
    parameter int DIV_W  = 8,
    parameter int IDLE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              stop_req_i,
    output logic              stop_ack_o,
    input  logic              auto_idle_i,
    input  logic [IDLE_W-1:0] idle_limit_i,
    input  logic              bus_busy_i,
    output logic              clk_en_o,
    output logic              sd_edge_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_STOPPED  = 2'd3
    } state_t;

    localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

    state_t            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              idle_stop_q;
    logic              clk_en_q;
    logic              sd_edge_q;
    logic              stop_ack_q;

    logic wrap;
    logic idle_hit;
    logic go_stop;
    logic resume;

    always_comb begin
        wrap     = (cnt_q == div_q);
        idle_hit = auto_idle_i && (idle_limit_i != '0) && (idle_cnt_q == idle_limit_i);
        go_stop  = stop_req_i || idle_hit;
        // An idle stop may only be woken by bus activity while auto-idle stays armed.
        resume   = !stop_req_i && (!auto_idle_i || bus_busy_i || !idle_stop_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            div_q       <= '0;
            idle_cnt_q  <= '0;
            idle_stop_q <= 1'b0;
            clk_en_q    <= 1'b0;
            sd_edge_q   <= 1'b0;
            stop_ack_q  <= 1'b0;
        end else begin
            sd_edge_q <= clk_en_q;
            clk_en_q  <= 1'b0;
            if (!enable_i) begin
                state_q     <= ST_OFF;
                cnt_q       <= '0;
                idle_cnt_q  <= '0;
                idle_stop_q <= 1'b0;
                stop_ack_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        div_q   <= div_i;
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            cnt_q <= '0;
                            div_q <= div_i;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // A wrap coinciding with the stop decision is already withheld.
                        if (go_stop) begin
                            state_q     <= ST_STOPPING;
                            idle_cnt_q  <= '0;
                            idle_stop_q <= idle_hit;
                        end else begin
                            clk_en_q <= wrap;
                            if (bus_busy_i) begin
                                idle_cnt_q <= '0;
                            end else if (wrap && (idle_cnt_q != IDLE_MAX)) begin
                                idle_cnt_q <= idle_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_STOPPING: begin
                        if (wrap) begin
                            state_q    <= ST_STOPPED;
                            cnt_q      <= '0;
                            div_q      <= div_i;
                            stop_ack_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_STOPPED: begin
                        cnt_q <= '0;
                        if (resume) begin
                            state_q     <= ST_RUN;
                            div_q       <= div_i;
                            stop_ack_q  <= 1'b0;
                            idle_stop_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                    end
                endcase
            end
        end
    end

    assign clk_en_o   = clk_en_q;
    assign sd_edge_o  = sd_edge_q;
    assign stop_ack_o = stop_ack_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sdio_clk_en_ctrl.sv
// Self-checking bench for sdio_clk_en_ctrl: cycle-level reference model plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_sdio_clk_en_ctrl;

    localparam int S_OFF      = 0;
    localparam int S_RUN      = 1;
    localparam int S_STOPPING = 2;
    localparam int S_STOPPED  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] div = 8'd0;
    logic       stop_req = 1'b0;
    logic       auto_idle = 1'b0;
    logic [7:0] idle_limit = 8'd0;
    logic       bus_busy = 1'b0;
    logic       stop_ack;
    logic       clk_en;
    logic       sd_edge;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    int m_state     = S_OFF;
    int m_elapsed   = 0;
    int m_period    = 1;
    int m_idle      = 0;
    bit m_idle_stop = 1'b0;
    bit m_en        = 1'b0;
    bit m_edge      = 1'b0;
    bit m_done;
    bit m_idle_hit;

    sdio_clk_en_ctrl #(.DIV_W(8), .IDLE_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .div_i        (div),
        .stop_req_i   (stop_req),
        .stop_ack_o   (stop_ack),
        .auto_idle_i  (auto_idle),
        .idle_limit_i (idle_limit),
        .bus_busy_i   (bus_busy),
        .clk_en_o     (clk_en),
        .sd_edge_o    (sd_edge),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input int dv, input bit stp,
                                 input bit aut, input int lim, input bit busy);
        enable     = en;
        div        = 8'(dv);
        stop_req   = stp;
        auto_idle  = aut;
        idle_limit = 8'(lim);
        bus_busy   = busy;
    endtask

    // Reference model: period length, cycles elapsed in it, idle pulse tally.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_state = S_OFF; m_elapsed = 0; m_period = 1; m_idle = 0;
            m_idle_stop = 1'b0; m_en = 1'b0; m_edge = 1'b0;
        end else begin
            m_edge = m_en;
            m_en   = 1'b0;
            m_done = (m_elapsed + 1 == m_period);
            m_idle_hit = auto_idle && (idle_limit != 8'd0) && (m_idle == int'(idle_limit));
            if (!enable) begin
                m_state = S_OFF; m_elapsed = 0; m_idle = 0; m_idle_stop = 1'b0;
            end else if (m_state == S_OFF) begin
                m_state = S_RUN; m_elapsed = 0; m_period = int'(div) + 1;
            end else if (m_state == S_RUN || m_state == S_STOPPING) begin
                if (m_done) begin
                    m_elapsed = 0; m_period = int'(div) + 1;
                end else begin
                    m_elapsed++;
                end
                if (m_state == S_STOPPING) begin
                    if (m_done) m_state = S_STOPPED;
                end else if (stop_req || m_idle_hit) begin
                    m_state = S_STOPPING; m_idle = 0; m_idle_stop = m_idle_hit;
                end else begin
                    m_en = m_done;
                    if (bus_busy) m_idle = 0;
                    else if (m_done && m_idle < 255) m_idle++;
                end
            end else begin
                if (!stop_req && (!auto_idle || bus_busy || !m_idle_stop)) begin
                    m_state = S_RUN; m_elapsed = 0; m_period = int'(div) + 1; m_idle_stop = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_clk_en", int'(clk_en), int'(m_en));
        checkOutput("model_sd_edge", int'(sd_edge), int'(m_edge));
        checkOutput("model_stop_ack", int'(stop_ack), (m_state == S_STOPPED) ? 1 : 0);
        checkOutput("model_state", int'(state), m_state);
    end

    task automatic capture(input int n, output int en_pat, output int edge_pat,
                           output int st1, output int ack1);
        en_pat = 0; edge_pat = 0; st1 = 0; ack1 = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (clk_en) en_pat |= (1 << i);
            if (sd_edge) edge_pat |= (1 << i);
            if (i == 1) begin
                st1 = int'(state);
                ack1 = int'(stop_ack);
            end
        end
    endtask

    task automatic waitState(input int target, input int bound, input string nm, output int pulses);
        bit hit;
        hit = 1'b0;
        pulses = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (clk_en) pulses++;
            if (int'(state) == target) hit = 1'b1;
        end
        if (!hit) checkOutput(nm, 0, 1);
    endtask

    task automatic waitPulse(input int bound, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (clk_en) hit = 1'b1;
        end
        if (!hit) checkOutput(nm, 0, 1);
    endtask

    initial begin
        int en_pat, edge_pat, st1, ack1, pulses, high_cnt, stops;
        bit r_en, r_stp, r_aut, r_busy;
        int r_div, r_lim;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_clk_en", int'(clk_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Enable with div=3: first pulse 4 cycles after RUN entry, then every 4
        applyStimulus(1, 3, 0, 0, 0, 0);
        capture(12, en_pat, edge_pat, st1, ack1);
        checkOutput("div3_state_run", st1, 1);
        checkOutput("div3_pulse_pattern", en_pat, 32'h220);
        checkOutput("div3_edge_pattern", edge_pat, 32'h440);

        // Full rate, then div=2 taking effect at the next wrap
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (8) @(negedge clk);
        high_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (clk_en) high_cnt++;
        end
        checkOutput("div0_continuous", high_cnt, 5);
        applyStimulus(1, 2, 0, 0, 0, 0);
        capture(10, en_pat, edge_pat, st1, ack1);
        checkOutput("div2_switch_pattern", en_pat, 32'h492);

        // Flow-control stop raised right after a pulse, then release
        applyStimulus(1, 3, 0, 0, 0, 0);
        waitPulse(10, "stop_pre_pulse_timeout");
        applyStimulus(1, 3, 1, 0, 0, 0);
        waitState(S_STOPPED, 20, "stop_reach_timeout", pulses);
        checkOutput("stop_suppressed_pulses", pulses, 0);
        checkOutput("stop_ack_high", int'(stop_ack), 1);
        applyStimulus(1, 3, 0, 0, 0, 0);
        capture(12, en_pat, edge_pat, st1, ack1);
        checkOutput("resume_state", st1, 1);
        checkOutput("resume_ack_low", ack1, 0);
        checkOutput("resume_pulse_pattern", en_pat, 32'h220);

        // Auto-idle: exactly 5 non-busy pulses, wake on busy, limit 0 never stops
        applyStimulus(1, 1, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        applyStimulus(1, 1, 0, 1, 5, 0);
        waitState(S_STOPPED, 100, "idle_stop_timeout", pulses);
        checkOutput("idle_pulse_count", pulses, 5);
        applyStimulus(1, 1, 0, 1, 5, 1);
        waitState(S_RUN, 5, "idle_wake_timeout", pulses);
        applyStimulus(1, 1, 0, 1, 0, 0);
        stops = 0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (int'(state) == S_STOPPED) stops++;
            if (clk_en) pulses++;
        end
        checkOutput("limit0_no_stop", stops, 0);
        checkOutput("limit0_pulses_seen", (pulses > 0) ? 1 : 0, 1);

        // enable dropped in STOPPING, and together with stop_req in STOPPED
        applyStimulus(1, 3, 1, 0, 0, 0);
        waitState(S_STOPPING, 10, "stopping_timeout", pulses);
        applyStimulus(0, 3, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("off_from_stopping_state", int'(state), 0);
        checkOutput("off_from_stopping_clk_en", int'(clk_en), 0);
        checkOutput("off_from_stopping_ack", int'(stop_ack), 0);
        applyStimulus(1, 3, 1, 0, 0, 0);
        waitState(S_STOPPED, 20, "stopped_timeout", pulses);
        applyStimulus(0, 3, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("off_from_stopped_state", int'(state), 0);
        checkOutput("off_from_stopped_ack", int'(stop_ack), 0);

        // Randomized soak against the model
        r_en = 1'b1; r_div = 2; r_stp = 1'b0; r_aut = 1'b0; r_lim = 3; r_busy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (r_en) r_en = ($urandom_range(0, 39) != 0);
            else      r_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) r_div = $urandom_range(0, 5);
            if ($urandom_range(0, 11) == 0) r_stp = !r_stp;
            if ($urandom_range(0, 49) == 0) r_aut = !r_aut;
            if ($urandom_range(0, 29) == 0) r_lim = $urandom_range(0, 6);
            r_busy = ($urandom_range(0, 5) == 0);
            applyStimulus(r_en, r_div, r_stp, r_aut, r_lim, r_busy);
            @(negedge clk);
        end

        // Asynchronous reset while clk_en is high
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitPulse(30, "reset_pre_pulse_timeout");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_clk_en", int'(clk_en), 0);
        checkOutput("async_rst_sd_edge", int'(sd_edge), 0);
        checkOutput("async_rst_stop_ack", int'(stop_ack), 0);
        checkOutput("async_rst_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
